// File: rtl/switch_pkg.sv
// Shared types and helpers for the 3x3 packet switch scheduler.
package switch_pkg;

  localparam int NPORTS         = 3;
  localparam int ADDR_W_DEFAULT = 12;

  // Megamux select value meaning "no input routed".
  localparam logic [1:0] SEL_NONE     = 2'd0;
  // Head destination code that marks a word to be discarded.
  localparam logic [1:0] DEST_INVALID = 2'd0;

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_WAIT,
    S_GRANT,
    S_XFER
  } sched_state_t;

  // Cyclic successor over ports 1..3; 0 (never a real pointer) maps to 1.
  function automatic logic [1:0] next_port(input logic [1:0] p);
    return (p == 2'd1) ? 2'd2 : (p == 2'd2) ? 2'd3 : 2'd1;
  endfunction

  function automatic logic [1:0] popcount3(input logic [2:0] v);
    return {1'b0, v[0]} + {1'b0, v[1]} + {1'b0, v[2]};
  endfunction

endpackage

// File: rtl/rr_arbiter3.sv
// Combinational 3-way round-robin arbiter: the first requester after the
// last winner (cyclic 1->2->3->1) wins. The pointer register lives outside.
module rr_arbiter3
  import switch_pkg::*;
(
  input  logic [NPORTS-1:0] req,
  input  logic [1:0]        last_grant,
  output logic [NPORTS-1:0] gnt,
  output logic [1:0]        win
);

  logic [1:0] c1, c2, c3;

  assign c1 = next_port(last_grant);
  assign c2 = next_port(c1);
  assign c3 = next_port(c2);

  // Pick the highest-priority requester; later assignments override earlier.
  always_comb begin
    win = SEL_NONE;
    if (req[c3 - 2'd1]) win = c3;
    if (req[c2 - 2'd1]) win = c2;
    if (req[c1 - 2'd1]) win = c1;
  end

  // One-hot form of the encoded winner.
  always_comb begin
    gnt = '0;
    for (int n = 0; n < NPORTS; n++) gnt[n] = (win == 2'(n + 1));
  end

endmodule

// File: rtl/crossbar_scheduler.sv
// Scheduler for the 3-in / 3-out packet switch. Each 4-cycle round reads the
// head word of every non-empty input RAM, arbitrates each output round-robin,
// drives the megamux selects / output FIFO write strobes for one cycle, then
// advances the read pointers of inputs that were forwarded or dropped.
module crossbar_scheduler
  import switch_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEFAULT,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic [ADDR_W-1:0] wr_ptr1,
  input  logic [ADDR_W-1:0] wr_ptr2,
  input  logic [ADDR_W-1:0] wr_ptr3,
  input  logic [31:0]       head1,
  input  logic [31:0]       head2,
  input  logic [31:0]       head3,
  input  logic              out_full1,
  input  logic              out_full2,
  input  logic              out_full3,
  output logic [ADDR_W-1:0] rd_add1,
  output logic [ADDR_W-1:0] rd_add2,
  output logic [ADDR_W-1:0] rd_add3,
  output logic              rden1,
  output logic              rden2,
  output logic              rden3,
  output logic [1:0]        mux_sel1,
  output logic [1:0]        mux_sel2,
  output logic [1:0]        mux_sel3,
  output logic              out_wr1,
  output logic              out_wr2,
  output logic              out_wr3,
  output logic              busy,
  output logic [CNT_W-1:0]  drop_count,
  output logic [CNT_W-1:0]  grant_count
);

  localparam int CW1 = CNT_W + 1;

  sched_state_t state, state_nxt;

  logic [NPORTS-1:0][ADDR_W-1:0] wr_ptr, rd_ptr, rd_ptr_nxt;
  logic [NPORTS-1:0][1:0]        dest, rr_ptr, win, mux_sel;
  logic [NPORTS-1:0][NPORTS-1:0] gnt;
  logic [NPORTS-1:0]             out_full, nonempty, valid, rden, out_wr;
  logic [NPORTS-1:0]             in_gnt, in_drop, gnt_q, drop_q, adv;
  logic [1:0]                    n_grant, n_drop;
  logic [CNT_W:0]                gsum, dsum;
  logic                          unused_head;

  // Index 0 is port 1 throughout.
  assign wr_ptr   = {wr_ptr3, wr_ptr2, wr_ptr1};
  assign dest     = {head3[1:0], head2[1:0], head1[1:0]};
  assign out_full = {out_full3, out_full2, out_full1};

  // Only the destination field of a head word matters to scheduling.
  assign unused_head = ^{head1[31:2], head2[31:2], head3[31:2]};

  // Read address is the read pointer itself, so it always names the head word.
  assign {rd_add3, rd_add2, rd_add1}    = rd_ptr;
  assign {rden3, rden2, rden1}          = rden;
  assign {mux_sel3, mux_sel2, mux_sel1} = mux_sel;
  assign {out_wr3, out_wr2, out_wr1}    = out_wr;
  assign busy = (state != S_IDLE);

  // Per-output request vector and round-robin arbiter; a full output FIFO
  // simply sees no requests this round.
  for (genvar k = 0; k < NPORTS; k++) begin : g_out
    logic [NPORTS-1:0] req;

    // Input n requests output k when its latched head is valid and targets k.
    always_comb begin
      req = '0;
      for (int n = 0; n < NPORTS; n++)
        req[n] = valid[n] && (dest[n] == 2'(k + 1)) && !out_full[k];
    end

    rr_arbiter3 u_arb (
      .req       (req),
      .last_grant(rr_ptr[k]),
      .gnt       (gnt[k]),
      .win       (win[k])
    );
  end

  // Per-input view of the arbitration result: granted somewhere, or dropped.
  always_comb begin
    in_gnt  = '0;
    in_drop = '0;
    for (int n = 0; n < NPORTS; n++) begin
      for (int k = 0; k < NPORTS; k++) in_gnt[n] = in_gnt[n] | gnt[k][n];
      in_drop[n] = valid[n] && (dest[n] == DEST_INVALID);
    end
  end

  // Pointer advance happens only on the transfer cycle; emptiness for the
  // next round is judged against the already-advanced pointers.
  always_comb begin
    adv = (state == S_XFER) ? (gnt_q | drop_q) : '0;
    for (int n = 0; n < NPORTS; n++) begin
      rd_ptr_nxt[n] = rd_ptr[n] + ADDR_W'(adv[n]);
      nonempty[n]   = (rd_ptr_nxt[n] != wr_ptr[n]);
    end
  end

  // Saturating counter sums.
  assign n_grant = popcount3(gnt_q);
  assign n_drop  = popcount3(drop_q);
  assign gsum    = {1'b0, grant_count} + CW1'(n_grant);
  assign dsum    = {1'b0, drop_count} + CW1'(n_drop);

  // Round sequencing.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (enable && |nonempty) state_nxt = S_READ;
      S_READ:  state_nxt = S_WAIT;
      S_WAIT:  state_nxt = S_GRANT;
      S_GRANT: state_nxt = S_XFER;
      S_XFER:  state_nxt = (enable && |nonempty) ? S_READ : S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Datapath registers: read strobes, grants, pointers and counters.
  always_ff @(posedge clk) begin
    if (!reset) begin
      rd_ptr      <= '0;
      rr_ptr      <= {NPORTS{2'd3}};
      valid       <= '0;
      rden        <= '0;
      mux_sel     <= '0;
      out_wr      <= '0;
      gnt_q       <= '0;
      drop_q      <= '0;
      drop_count  <= '0;
      grant_count <= '0;
    end else begin
      rd_ptr <= rd_ptr_nxt;
      rden   <= (state_nxt == S_READ) ? nonempty : '0;
      if (state_nxt == S_READ) valid <= nonempty;

      if (state == S_GRANT) begin
        mux_sel <= win;
        for (int k = 0; k < NPORTS; k++) out_wr[k] <= (win[k] != SEL_NONE);
        gnt_q  <= in_gnt;
        drop_q <= in_drop;
      end else begin
        mux_sel <= '0;
        out_wr  <= '0;
        gnt_q   <= '0;
        drop_q  <= '0;
      end

      if (state == S_XFER) begin
        for (int k = 0; k < NPORTS; k++)
          if (mux_sel[k] != SEL_NONE) rr_ptr[k] <= mux_sel[k];
        grant_count <= gsum[CNT_W] ? '1 : gsum[CNT_W-1:0];
        drop_count  <= dsum[CNT_W] ? '1 : dsum[CNT_W-1:0];
      end
    end
  end

endmodule
